spi_slave_sequencer: RTL and testbench
======================================

# spi_slave_sequencer

Byte-level transaction controller that sits behind the SPI slave shift engine in the `sysClk` domain and turns a stream of received SPI bytes into register-bus reads and writes. The first byte of each chip-select frame is a command (R/W bit plus start address). Following bytes are either written to the bus at auto-incrementing addresses, or are prefetched from the bus and presented on `tx_byte` for the slave to shift out. It owns the single register-bus master port and reports overrun when SPI traffic outpaces the bus.

## Interface

Parameters:
- ADDR_WIDTH, 7, bus address width. The command byte carries 7 address bits, zero-extended if ADDR_WIDTH > 7.

Ports:
- sysClk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cs_active  in  1  synchronized chip-select; level, 1 = frame in progress.
- byte_valid  in  1  one-cycle pulse; a full byte has been exchanged and rx_byte is valid.
- rx_byte  in  8  received byte.
- tx_byte  out  8  byte the slave shifts out during the next byte slot.
- bus_req  out  1  bus request; held until bus_ack.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
- bus_addr  out  ADDR_WIDTH  bus address; stable while bus_req is high.
- bus_wdata  out  8  write data; stable while bus_req is high.
- bus_rdata  in  8  read data; valid in the bus_ack cycle.
- bus_ack  in  1  one-cycle completion strobe.
- busy  out  1  high in every state except SqIdle.
- overrun  out  1  sticky error flag; cleared on the next cs_active rising edge or on reset.

## Operation

- Command byte format:
  - bit7 = 1: read command.
  - bit7 = 0: write command.
  - bits[6:0]: start address.
- States:
  - SqIdle:
    - cs_active rising edge -> SqCmd.
    - The overrun clear happens on this transition.
  - SqCmd:
    - byte_valid with bit7 = 0 -> SqWrData; address register loaded.
    - byte_valid with bit7 = 1 -> SqRdFetch; address register loaded.
  - SqWrData: byte_valid -> capture rx_byte into bus_wdata, go to SqWrBus.
  - SqWrBus:
    - bus_req = 1, bus_we = 1.
    - On bus_ack: address increments, go to SqWrData.
  - SqRdFetch:
    - bus_req = 1, bus_we = 0.
    - On bus_ack: tx_byte <= bus_rdata, address increments, go to SqRdStream.
  - SqRdStream: byte_valid (the prefetched byte has been consumed) -> SqRdFetch.
- Address arithmetic: modulo 2^ADDR_WIDTH; the all-ones address wraps to 0 with no flag.
- Overrun:
  - Trigger: byte_valid arrives while in SqWrBus or SqRdFetch. overrun is set.
  - Write case: the byte is dropped.
  - Read case: the slave has re-sent a stale tx_byte.
  - The state machine does not advance.
- cs_active falls in any state:
  - If bus_req is high, the request completes normally (bus requests are never abandoned), then the machine goes to SqIdle.
  - Otherwise the machine goes directly to SqIdle on the next cycle.
  - A partially received frame is discarded.
- tx_byte is 8'h00 in SqIdle and SqCmd. The master reads 0x00 during the command byte.
- Reset in any state, including with bus_req high:
  - Next cycle: SqIdle, and bus_req is dropped immediately.
  - The bus must tolerate a dropped request across reset.

## Timing

- Reset values:
  - tx_byte = 8'h00, bus_wdata = 8'h00, bus_addr = 0.
  - bus_req = 0, bus_we = 0, busy = 0, overrun = 0.
- bus_req is registered. It asserts one cycle after the byte_valid or ack that enters SqWrBus or SqRdFetch.
- bus_req deasserts the cycle after bus_ack.
- Minimum request-to-ack latency: 0 (ack in the first req cycle is legal).
- Read path: tx_byte updates the cycle after bus_ack. The bus must ack within one SPI byte period, or overrun results.
- Simultaneous bus_ack and byte_valid in SqRdFetch:
  - The ack is processed and the state becomes SqRdStream.
  - The byte_valid counts as an overrun.
  - Same rule applies in SqWrBus.
- Simultaneous cs_active fall and byte_valid: the byte is ignored and no bus cycle starts.

## Structure

- Package spi_seq_pkg holds:
  - SeqState enum (SqIdle, SqCmd, SqWrData, SqWrBus, SqRdFetch, SqRdStream).
  - CMD_READ_BIT = 7.
  - TX_IDLE_BYTE = 8'h00.
- Single module with no sub-module. The cs_active edge detect is one local register.
- CDC is already handled upstream; every input is treated as synchronous to sysClk.

## Test plan

- Write burst:
  - Stimulus: cs_active high; bytes 0x10, 0xAA, 0xBB.
  - Required: bus writes (0x10, 0xAA) and (0x11, 0xBB), each req held until ack; busy falls after cs_active drops.
- Read burst:
  - Stimulus: command 0x85; bus returns 0x3C at address 0x05 and 0x4D at 0x06.
  - Required: tx_byte = 0x3C after the first ack; 0x4D after the second byte_valid plus ack.
- Address wrap:
  - Stimulus: ADDR_WIDTH = 7; write command 0x7F followed by 2 data bytes.
  - Required: bus_addr sequence is 0x7F, then 0x00.
- Overrun:
  - Stimulus: hold bus_ack low; send a second data byte.
  - Required: overrun = 1, the byte is dropped, overrun clears on the next frame start.
- Abort:
  - Stimulus: drop cs_active during SqRdFetch.
  - Required: bus_req stays high until ack, then SqIdle; a new frame decodes a fresh command.
- Reset:
  - Stimulus: assert reset while bus_req = 1.
  - Required: next cycle all outputs at reset values and state SqIdle.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI slave byte sequencer.
package spi_seq_pkg;

   typedef enum logic [2:0] {
      SqIdle,
      SqCmd,
      SqWrData,
      SqWrBus,
      SqRdFetch,
      SqRdStream
   } SeqState;

   localparam int         CMD_READ_BIT = 7;
   localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_slave_sequencer.sv
// Turns the bytes of a chip-select frame into register-bus writes or prefetched reads; bus_req is registered, one cycle after the trigger.
// No backpressure toward SPI: a byte arriving while a bus cycle is pending sets the sticky overrun flag and is dropped.
module spi_slave_sequencer
   import spi_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  sysClk,
   input  logic                  reset,
   input  logic                  cs_active,
   input  logic                  byte_valid,
   input  logic [7:0]            rx_byte,
   output logic [7:0]            tx_byte,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [7:0]            bus_wdata,
   input  logic [7:0]            bus_rdata,
   input  logic                  bus_ack,
   output logic                  busy,
   output logic                  overrun
);

   SeqState               state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            wdata_q, wdata_d;
   logic [7:0]            tx_q, tx_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;
   logic                  cs_prev_q, cs_prev_d;
   logic                  byte_in;

   // A byte coinciding with the chip-select fall belongs to no frame.
   assign byte_in = byte_valid && cs_active;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      overrun_d = overrun_q;
      cs_prev_d = cs_active;

      case (state_q)
         SqIdle: begin
            if (cs_active && !cs_prev_q) begin
               state_d   = SqCmd;
               overrun_d = 1'b0;
            end
         end
         SqCmd: begin
            if (!cs_active) begin
               state_d = SqIdle;
            end else if (byte_valid) begin
               addr_d  = ADDR_WIDTH'(rx_byte[CMD_READ_BIT-1:0]);
               state_d = rx_byte[CMD_READ_BIT] ? SqRdFetch : SqWrData;
            end
         end
         SqWrData: begin
            if (!cs_active) begin
               state_d = SqIdle;
            end else if (byte_valid) begin
               wdata_d = rx_byte;
               state_d = SqWrBus;
            end
         end
         SqWrBus, SqRdFetch: begin
            // A pending request always runs to its ack, even after chip-select drops.
            if (byte_in) begin
               overrun_d = 1'b1;
            end
            if (bus_ack) begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (!cs_active) begin
                  state_d = SqIdle;
               end else begin
                  state_d = (state_q == SqWrBus) ? SqWrData : SqRdStream;
               end
            end
         end
         SqRdStream: begin
            if (!cs_active) begin
               state_d = SqIdle;
            end else if (byte_valid) begin
               state_d = SqRdFetch;
            end
         end
         default: state_d = SqIdle;
      endcase

      req_d  = (state_d == SqWrBus) || (state_d == SqRdFetch);
      we_d   = (state_d == SqWrBus);
      busy_d = (state_d != SqIdle);

      if (state_d == SqIdle || state_d == SqCmd) begin
         tx_d = TX_IDLE_BYTE;
      end else if (state_q == SqRdFetch && bus_ack) begin
         tx_d = bus_rdata;
      end else begin
         tx_d = tx_q;
      end
   end

   always_ff @(posedge sysClk) begin
      if (reset) begin
         state_q   <= SqIdle;
         addr_q    <= '0;
         wdata_q   <= 8'h00;
         tx_q      <= TX_IDLE_BYTE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         // Tracking cs through reset keeps a frame already in flight from looking like a new one.
         cs_prev_q <= cs_active;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_q      <= tx_d;
         req_q     <= req_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         cs_prev_q <= cs_prev_d;
      end
   end

   assign tx_byte   = tx_q;
   assign bus_req   = req_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// Bench for spi_slave_sequencer with a memory-backed register bus and random ack latency.
module tb_spi_slave_sequencer;

   localparam int AW = 7;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } txn_t;

   logic          sysClk;
   logic          reset;
   logic          cs_active;
   logic          byte_valid;
   logic [7:0]    rx_byte;
   logic [7:0]    tx_byte;
   logic          bus_req;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [7:0]    bus_wdata;
   logic [7:0]    bus_rdata;
   logic          bus_ack;
   logic          busy;
   logic          overrun;

   txn_t       log_q[$];
   txn_t       exp_q[$];
   logic [7:0] frame_data[$];
   logic [7:0] ref_mem[128];
   logic [7:0] bus_mem[128];
   int         n_checks;
   int         n_fail;
   int         wait_cnt;
   int         lat_tgt;
   bit         ack_hold;

   spi_slave_sequencer #(.ADDR_WIDTH(AW)) dut (
      .sysClk    (sysClk),
      .reset     (reset),
      .cs_active (cs_active),
      .byte_valid(byte_valid),
      .rx_byte   (rx_byte),
      .tx_byte   (tx_byte),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock; pulses drop, then the bus slave answers a pending request.
   task automatic tick();
      txn_t t;
      @(posedge sysClk);
      #1;
      byte_valid = 1'b0;
      bus_ack    = 1'b0;
      bus_rdata  = 8'($urandom);
      if (bus_req && !ack_hold) begin
         if (wait_cnt >= lat_tgt) begin
            bus_ack = 1'b1;
            t.we    = bus_we;
            t.addr  = bus_addr;
            if (bus_we) begin
               t.data            = bus_wdata;
               bus_mem[bus_addr] = bus_wdata;
            end else begin
               bus_rdata = bus_mem[bus_addr];
               t.data    = bus_rdata;
            end
            log_q.push_back(t);
            wait_cnt = 0;
            lat_tgt  = $urandom_range(0, 3);
         end else begin
            wait_cnt++;
         end
      end else if (!bus_req) begin
         wait_cnt = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte    = b;
      byte_valid = 1'b1;
   endtask

   task automatic wait_ack(input string tag, input int n0);
      for (int i = 0; i < 20 && log_q.size() == n0; i++) tick();
      check_val({tag, "_ack"}, 32'(log_q.size()), 32'(n0 + 1));
   endtask

   task automatic push_exp(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      txn_t t;
      t.we   = we;
      t.addr = a;
      t.data = d;
      exp_q.push_back(t);
   endtask

   task automatic compare_log(input string tag);
      check_val({tag, "_ntxn"}, 32'(log_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < log_q.size()) begin
            check_val($sformatf("%s_we%0d", tag, i),   32'(log_q[i].we),   32'(exp_q[i].we));
            check_val($sformatf("%s_addr%0d", tag, i), 32'(log_q[i].addr), 32'(exp_q[i].addr));
            check_val($sformatf("%s_data%0d", tag, i), 32'(log_q[i].data), 32'(exp_q[i].data));
         end
      end
   endtask

   task automatic frame_begin(input string tag);
      log_q.delete();
      exp_q.delete();
      cs_active = 1'b1;
      tick();
      tick();
      check_val({tag, "_txcmd"}, 32'(tx_byte), 32'h00);
   endtask

   task automatic frame_end(input string tag);
      cs_active = 1'b0;
      tick();
      tick();
      check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
      check_val({tag, "_tx_end"}, 32'(tx_byte), 32'h00);
   endtask

   task automatic write_frame(input string tag, input logic [AW-1:0] start);
      logic [AW-1:0] a;
      int            n0;
      frame_begin(tag);
      send_byte({1'b0, start});
      tick();
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      foreach (frame_data[i]) begin
         a = start + AW'(i);
         push_exp(1'b1, a, frame_data[i]);
         ref_mem[a] = frame_data[i];
         n0 = log_q.size();
         send_byte(frame_data[i]);
         tick();
         check_val({tag, "_req"}, 32'(bus_req), 32'd1);
         check_val({tag, "_we"}, 32'(bus_we), 32'd1);
         check_val({tag, "_addr"}, 32'(bus_addr), 32'(a));
         check_val({tag, "_wdata"}, 32'(bus_wdata), 32'(frame_data[i]));
         wait_ack(tag, n0);
         tick();
         check_val({tag, "_reqdrop"}, 32'(bus_req), 32'd0);
         repeat ($urandom_range(0, 2)) tick();
      end
      frame_end(tag);
      compare_log(tag);
   endtask

   task automatic read_frame(input string tag, input logic [AW-1:0] start, input int n);
      logic [AW-1:0] a;
      int            n0;
      frame_begin(tag);
      for (int k = 0; k <= n; k++) begin
         a = start + AW'(k);
         push_exp(1'b0, a, ref_mem[a]);
         n0 = log_q.size();
         send_byte((k == 0) ? {1'b1, start} : 8'($urandom));
         tick();
         check_val({tag, "_req"}, 32'(bus_req), 32'd1);
         check_val({tag, "_we"}, 32'(bus_we), 32'd0);
         check_val({tag, "_addr"}, 32'(bus_addr), 32'(a));
         wait_ack(tag, n0);
         tick();
         check_val({tag, "_tx"}, 32'(tx_byte), 32'(ref_mem[a]));
         check_val({tag, "_reqdrop"}, 32'(bus_req), 32'd0);
         repeat ($urandom_range(0, 2)) tick();
      end
      frame_end(tag);
      compare_log(tag);
   endtask

   initial begin
      logic [7:0]    v;
      logic [AW-1:0] start;
      int            n0;
      reset      = 1'b1;
      cs_active  = 1'b0;
      byte_valid = 1'b0;
      rx_byte    = 8'h00;
      bus_rdata  = 8'h00;
      bus_ack    = 1'b0;
      ack_hold   = 1'b0;
      wait_cnt   = 0;
      lat_tgt    = 0;
      n_checks   = 0;
      n_fail     = 0;
      for (int i = 0; i < 128; i++) begin
         v          = 8'($urandom);
         ref_mem[i] = v;
         bus_mem[i] = v;
      end

      repeat (3) tick();
      check_val("rst_tx", 32'(tx_byte), 32'h00);
      check_val("rst_wdata", 32'(bus_wdata), 32'h00);
      check_val("rst_addr", 32'(bus_addr), 32'h00);
      check_val("rst_req", 32'(bus_req), 32'd0);
      check_val("rst_we", 32'(bus_we), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_ovr", 32'(overrun), 32'd0);
      reset = 1'b0;
      tick();

      frame_data = '{8'hAA, 8'hBB};
      write_frame("wr_burst", 7'h10);

      ref_mem[5] = 8'h3C; bus_mem[5] = 8'h3C;
      ref_mem[6] = 8'h4D; bus_mem[6] = 8'h4D;
      read_frame("rd_burst", 7'h05, 1);

      frame_data = '{8'hC1, 8'hC2};
      write_frame("wrap", 7'h7F);

      // Overrun: byte during a stalled write, then a byte coinciding with the ack.
      frame_begin("ovr");
      send_byte(8'h20);
      tick();
      ack_hold = 1'b1;
      send_byte(8'h11);
      tick();
      tick();
      send_byte(8'h22);
      tick();
      check_val("ovr_set", 32'(overrun), 32'd1);
      check_val("ovr_dropped", 32'(bus_wdata), 32'h11);
      check_val("ovr_req", 32'(bus_req), 32'd1);
      lat_tgt  = 0;
      ack_hold = 1'b0;
      tick();
      check_val("ovr_ack_now", 32'(log_q.size()), 32'd1);
      send_byte(8'h33);
      tick();
      check_val("ovr_simul_req", 32'(bus_req), 32'd0);
      check_val("ovr_simul_flag", 32'(overrun), 32'd1);
      tick();
      n0 = log_q.size();
      send_byte(8'h44);
      tick();
      check_val("ovr_next_addr", 32'(bus_addr), 32'h21);
      check_val("ovr_next_wdata", 32'(bus_wdata), 32'h44);
      wait_ack("ovr_next", n0);
      tick();
      push_exp(1'b1, 7'h20, 8'h11); ref_mem[7'h20] = 8'h11;
      push_exp(1'b1, 7'h21, 8'h44); ref_mem[7'h21] = 8'h44;
      cs_active = 1'b0;
      tick();
      tick();
      check_val("ovr_sticky", 32'(overrun), 32'd1);
      check_val("ovr_busy", 32'(busy), 32'd0);
      compare_log("ovr");
      cs_active = 1'b1;
      tick();
      tick();
      check_val("ovr_clear", 32'(overrun), 32'd0);
      cs_active = 1'b0;
      tick();
      tick();

      // Abort: chip-select drops while a read fetch is stalled.
      frame_begin("abort");
      ack_hold = 1'b1;
      send_byte(8'h90);
      tick();
      tick();
      cs_active = 1'b0;
      repeat (3) tick();
      check_val("abort_req_held", 32'(bus_req), 32'd1);
      check_val("abort_addr", 32'(bus_addr), 32'h10);
      ack_hold = 1'b0;
      wait_ack("abort", 0);
      tick();
      check_val("abort_req_drop", 32'(bus_req), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_tx", 32'(tx_byte), 32'h00);
      frame_data = '{8'h5A};
      write_frame("post_abort", 7'h12);

      // Reset while a write request is pending and overrun is set.
      log_q.delete();
      cs_active = 1'b1;
      tick();
      tick();
      send_byte(8'h40);
      tick();
      ack_hold = 1'b1;
      send_byte(8'h77);
      tick();
      send_byte(8'h78);
      tick();
      check_val("rstb_pre_req", 32'(bus_req), 32'd1);
      check_val("rstb_pre_ovr", 32'(overrun), 32'd1);
      reset = 1'b1;
      tick();
      check_val("rstb_tx", 32'(tx_byte), 32'h00);
      check_val("rstb_wdata", 32'(bus_wdata), 32'h00);
      check_val("rstb_addr", 32'(bus_addr), 32'h00);
      check_val("rstb_req", 32'(bus_req), 32'd0);
      check_val("rstb_we", 32'(bus_we), 32'd0);
      check_val("rstb_busy", 32'(busy), 32'd0);
      check_val("rstb_ovr", 32'(overrun), 32'd0);
      reset     = 1'b0;
      cs_active = 1'b0;
      ack_hold  = 1'b0;
      repeat (3) tick();
      check_val("rstb_nowrite", 32'(log_q.size()), 32'd0);
      frame_data = '{8'h9E};
      write_frame("post_rst", 7'h41);

      for (int f = 0; f < 40; f++) begin
         start = AW'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            read_frame($sformatf("rnd_rd%0d", f), start, $urandom_range(1, 4));
         end else begin
            frame_data.delete();
            repeat ($urandom_range(1, 4)) frame_data.push_back(8'($urandom));
            write_frame($sformatf("rnd_wr%0d", f), start);
         end
         check_val($sformatf("rnd_ovr%0d", f), 32'(overrun), 32'd0);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
